// File: rtl/instr_buffer_pkg.sv
// Shared fetch/dispatch types and sizing constants for the instruction buffer.
package instr_buffer_pkg;

    localparam int unsigned XLEN     = 32;
    localparam int unsigned IB_DEPTH = 8;

    typedef struct packed {
        logic [31:0]     inst;
        logic [XLEN-1:0] PC;
        logic [XLEN-1:0] NPC;
        logic            valid;
    } IF_IB_PACKET;

endpackage

// File: rtl/instr_buffer_if.sv
// Fetch/dispatch-facing bus of the instruction buffer; slave is the buffer side.
interface instr_buffer_if
    import instr_buffer_pkg::*;
#(
    parameter int unsigned DEPTH = IB_DEPTH
) ();

    localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

    IF_IB_PACKET      if_ib_packet;
    logic             squash;
    logic             dp_take;
    IF_IB_PACKET      ib_dp_packet;
    logic             ib_full;
    logic             ib_empty;
    logic [CNT_W-1:0] ib_count;

    modport slave (
        input  if_ib_packet,
        input  squash,
        input  dp_take,
        output ib_dp_packet,
        output ib_full,
        output ib_empty,
        output ib_count
    );

    modport master (
        output if_ib_packet,
        output squash,
        output dp_take,
        input  ib_dp_packet,
        input  ib_full,
        input  ib_empty,
        input  ib_count
    );

endinterface

// File: rtl/instr_buffer.sv
// In-order instruction FIFO between fetch and dispatch with squash flush.
// Status outputs come only from registered count; head output only from registers.
module instr_buffer
    import instr_buffer_pkg::*;
#(
    parameter int unsigned DEPTH       = IB_DEPTH,
    parameter bit          PROTO_CHECK = 1'b1
) (
    input  logic          clock,
    input  logic          reset,
    instr_buffer_if.slave ib
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
        $error("instr_buffer: DEPTH must be a power of two and at least 2");
    end

    IF_IB_PACKET      storage_q [DEPTH];
    logic [PTR_W-1:0] head_q, head_d;
    logic [PTR_W-1:0] tail_q, tail_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             full;
    logic             empty;
    logic             push;
    logic             pop;
    IF_IB_PACKET      head_pkt;

    always_comb begin
        full  = (count_q == CNT_W'(DEPTH));
        empty = (count_q == '0);
        push  = ib.if_ib_packet.valid && !full && !ib.squash;
        pop   = ib.dp_take && !empty && !ib.squash;
    end

    // Pointer/count next state; squash wins over any push or pop this cycle.
    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        if (ib.squash) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end else begin
            if (push) begin
                tail_d = tail_q + PTR_W'(1);
            end
            if (pop) begin
                head_d = head_q + PTR_W'(1);
            end
            if (push && !pop) begin
                count_d = count_q + CNT_W'(1);
            end else if (pop && !push) begin
                count_d = count_q - CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    // Payload storage carries no reset; occupancy alone decides what is live.
    always_ff @(posedge clock) begin
        if (!reset && push) begin
            storage_q[tail_q] <= ib.if_ib_packet;
        end
    end

    always_comb begin
        head_pkt       = storage_q[head_q];
        head_pkt.valid = 1'b1;
        ib.ib_dp_packet = empty ? '0 : head_pkt;
        ib.ib_full      = full;
        ib.ib_empty     = empty;
        ib.ib_count     = count_q;
    end

    if (PROTO_CHECK) begin : g_proto_check
        a_no_push_when_full: assert property (@(posedge clock) disable iff (reset)
            !(ib.if_ib_packet.valid && full))
            else $error("instr_buffer: fetch presented a valid packet while full");
    end

endmodule

// File: tb/tb_instr_buffer.sv
// Self-checking bench for instr_buffer: directed vector table, corner sequences, random vs queue model.
module tb_instr_buffer;
    import instr_buffer_pkg::*;

    localparam int unsigned D = IB_DEPTH;

    logic clock = 1'b0;
    logic reset;

    always #5 clock = ~clock;

    instr_buffer_if #(.DEPTH(D)) bus ();

    instr_buffer #(.DEPTH(D), .PROTO_CHECK(1'b0)) dut (
        .clock (clock),
        .reset (reset),
        .ib    (bus)
    );

    int n_tests = 0;
    int n_fail  = 0;

    IF_IB_PACKET model_q [$];

    typedef struct {
        logic            valid;
        logic [XLEN-1:0] pc;
        logic            take;
        int unsigned     exp_cnt;
        logic            exp_full;
        logic            exp_empty;
        logic [XLEN-1:0] exp_head;
    } vec_t;

    vec_t vecs [$];

    function automatic IF_IB_PACKET mk(input logic v, input logic [XLEN-1:0] pc);
        IF_IB_PACKET p;
        p.inst  = pc ^ 32'h0013_5A5A;
        p.PC    = pc;
        p.NPC   = pc + XLEN'(4);
        p.valid = v;
        return p;
    endfunction

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Expected outputs derived from the queue model: occupancy and oldest entry.
    task automatic check_model();
        IF_IB_PACKET exp_pkt;
        exp_pkt = '0;
        if (model_q.size() > 0) begin
            exp_pkt       = model_q[0];
            exp_pkt.valid = 1'b1;
        end
        chk("model_count", 128'(bus.ib_count), 128'(model_q.size()));
        chk("model_full",  128'(bus.ib_full),  128'(model_q.size() == D));
        chk("model_empty", 128'(bus.ib_empty), 128'(model_q.size() == 0));
        chk("model_head",  128'(bus.ib_dp_packet), 128'(exp_pkt));
    endtask

    task automatic step(input IF_IB_PACKET pkt, input logic sq, input logic take, input logic rst);
        bit can_push;
        bit can_pop;
        bus.if_ib_packet = pkt;
        bus.squash       = sq;
        bus.dp_take      = take;
        reset            = rst;
        can_push = pkt.valid && (model_q.size() < D);
        can_pop  = take && (model_q.size() > 0);
        @(posedge clock);
        if (rst || sq) begin
            model_q.delete();
        end else begin
            if (can_pop) void'(model_q.pop_front());
            if (can_push) model_q.push_back(pkt);
        end
        #1;
        check_model();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.if_ib_packet = '0;
        bus.squash       = 1'b0;
        bus.dp_take      = 1'b0;
        reset            = 1'b1;

        // Fill, overfill, drain, then push+take on empty.
        for (int i = 0; i < 8; i++)
            vecs.push_back('{1'b1, XLEN'(4 * i), 1'b0, i + 1, (i == 7), 1'b0, 32'h0});
        vecs.push_back('{1'b1, 32'h20, 1'b0, 8, 1'b1, 1'b0, 32'h0});
        for (int i = 0; i < 8; i++)
            vecs.push_back('{1'b0, 32'h0, 1'b1, 7 - i, 1'b0, (i == 7), XLEN'(4 * (i + 1))});
        vecs.push_back('{1'b1, 32'h40, 1'b1, 1, 1'b0, 1'b0, 32'h40});

        step('0, 1'b0, 1'b0, 1'b1);
        step('0, 1'b0, 1'b0, 1'b1);
        chk("reset_count", 128'(bus.ib_count), 128'(0));
        chk("reset_empty", 128'(bus.ib_empty), 128'(1));
        chk("reset_full",  128'(bus.ib_full),  128'(0));
        chk("reset_head",  128'(bus.ib_dp_packet), 128'(0));

        foreach (vecs[i]) begin
            IF_IB_PACKET exp_pkt;
            step(mk(vecs[i].valid, vecs[i].pc), 1'b0, vecs[i].take, 1'b0);
            exp_pkt = vecs[i].exp_empty ? '0 : mk(1'b1, vecs[i].exp_head);
            chk("vec_count", 128'(bus.ib_count), 128'(vecs[i].exp_cnt));
            chk("vec_full",  128'(bus.ib_full),  128'(vecs[i].exp_full));
            chk("vec_empty", 128'(bus.ib_empty), 128'(vecs[i].exp_empty));
            chk("vec_head",  128'(bus.ib_dp_packet), 128'(exp_pkt));
        end

        // Steady push+pop at occupancy 3 across pointer wrap.
        step(mk(1'b1, 32'h44), 1'b0, 1'b0, 1'b0);
        step(mk(1'b1, 32'h48), 1'b0, 1'b0, 1'b0);
        chk("wrap_start_count", 128'(bus.ib_count), 128'(3));
        for (int k = 1; k <= 20; k++) begin
            step(mk(1'b1, XLEN'(32'h48 + 4 * k)), 1'b0, 1'b1, 1'b0);
            chk("wrap_count",   128'(bus.ib_count), 128'(3));
            chk("wrap_head_pc", 128'(bus.ib_dp_packet.PC), 128'(32'h40 + 4 * k));
        end

        // Squash at count 5 together with push and take.
        step(mk(1'b1, 32'h9C), 1'b0, 1'b0, 1'b0);
        step(mk(1'b1, 32'hA0), 1'b0, 1'b0, 1'b0);
        chk("squash_pre_count", 128'(bus.ib_count), 128'(5));
        step(mk(1'b1, 32'hDEAD0), 1'b1, 1'b1, 1'b0);
        chk("squash_count", 128'(bus.ib_count), 128'(0));
        chk("squash_empty", 128'(bus.ib_empty), 128'(1));
        chk("squash_valid", 128'(bus.ib_dp_packet.valid), 128'(0));
        step('0, 1'b0, 1'b0, 1'b0);
        chk("squash_idle_empty", 128'(bus.ib_empty), 128'(1));
        step(mk(1'b1, 32'h100), 1'b0, 1'b0, 1'b0);
        chk("squash_next_head", 128'(bus.ib_dp_packet), 128'(mk(1'b1, 32'h100)));

        // Full boundary: push blocked while full even with take; resumes next cycle.
        for (int k = 1; k < 8; k++)
            step(mk(1'b1, XLEN'(32'h100 + 4 * k)), 1'b0, 1'b0, 1'b0);
        chk("fullb_full", 128'(bus.ib_full), 128'(1));
        step(mk(1'b1, 32'h200), 1'b0, 1'b1, 1'b0);
        chk("fullb_count", 128'(bus.ib_count), 128'(7));
        chk("fullb_deassert", 128'(bus.ib_full), 128'(0));
        chk("fullb_head", 128'(bus.ib_dp_packet.PC), 128'(32'h104));
        step(mk(1'b1, 32'h204), 1'b0, 1'b0, 1'b0);
        chk("fullb_refill_count", 128'(bus.ib_count), 128'(8));
        chk("fullb_refill_full",  128'(bus.ib_full),  128'(1));

        // Reset mid-stream outranks everything.
        step(mk(1'b1, 32'h300), 1'b1, 1'b1, 1'b1);
        chk("midreset_count", 128'(bus.ib_count), 128'(0));
        chk("midreset_head",  128'(bus.ib_dp_packet), 128'(0));

        // Random traffic against the queue model.
        for (int n = 0; n < 600; n++) begin
            logic v, t, s, r;
            v = ($urandom_range(0, 3) != 0);
            t = ($urandom_range(0, 2) != 0);
            s = ($urandom_range(0, 31) == 0);
            r = ($urandom_range(0, 99) == 0);
            step(mk(v, XLEN'($urandom)), s, t, r);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
